agex_stage_pipe: RTL and testbench



---
 rtl/agex_pkg.sv | 17 +
 rtl/agex_shift_unit.sv | 19 +
 rtl/agex_stage_pipe.sv | 130 +++++++++++++
 tb/tb_agex_stage_pipe.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/agex_pkg.sv
// agex_pkg: control-store field positions, ALU opcodes and AGEX FSM states
package agex_pkg;
  localparam int CS_ADDR1MUX   = 0;
  localparam int CS_ADDR2MUX   = 1;
  localparam int CS_LSHF1      = 3;
  localparam int CS_ADDRESSMUX = 4;
  localparam int CS_SR2MUX     = 5;
  localparam int CS_ALUK       = 6;
  localparam int CS_RESULTMUX  = 8;
  localparam int CS_MEM_LO     = 9;
  localparam int CS_MEM_HI     = 19;
  localparam int CS_BR_STALL   = 12;
  localparam int CS_LD_REG     = 18;
  localparam int CS_LD_CC      = 19;
  typedef enum logic [1:0] {ALUK_ADD = 2'b00, ALUK_AND = 2'b01, ALUK_XOR = 2'b10, ALUK_PASSA = 2'b11} aluk_e;
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_e;
endpackage

// File: rtl/agex_shift_unit.sv
// agex_shift_unit: barrel shift by IR amount plus a one-bit step for the iterative shifter
module agex_shift_unit #(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] bar_in,
  input  logic [3:0]        amt,
  input  logic [DATA_W-1:0] step_in,
  input  logic [1:0]        mode,
  output logic [DATA_W-1:0] bar_out,
  output logic [DATA_W-1:0] step_out
);
  logic signed [DATA_W-1:0] sra;
  // mode[0]=0 left, mode[0]=1 right; mode[1] selects arithmetic right shift
  always_comb begin
    sra      = $signed(bar_in) >>> amt;
    bar_out  = !mode[0] ? bar_in << amt : mode[1] ? sra : bar_in >> amt;
    step_out = !mode[0] ? {step_in[DATA_W-2:0], 1'b0} : {mode[1] & step_in[DATA_W-1], step_in[DATA_W-1:1]};
  end
endmodule

// File: rtl/agex_stage_pipe.sv
// agex_stage_pipe: address-generate/execute stage with optional iterative shifter feeding the MEM latch
module agex_stage_pipe
  import agex_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int SHIFT_ITER = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              agex_v,
  input  logic [DATA_W-1:0] agex_npc,
  input  logic [15:0]       agex_ir,
  input  logic [DATA_W-1:0] agex_sr1,
  input  logic [DATA_W-1:0] agex_sr2,
  input  logic [2:0]        agex_cc,
  input  logic [2:0]        agex_drid,
  input  logic [19:0]       agex_cs,
  input  logic              mem_stall,
  input  logic              flush,
  output logic              mem_v,
  output logic [DATA_W-1:0] mem_npc,
  output logic [15:0]       mem_ir,
  output logic [DATA_W-1:0] mem_alu_result,
  output logic [DATA_W-1:0] mem_address,
  output logic [2:0]        mem_cc,
  output logic [2:0]        mem_drid,
  output logic [10:0]       mem_cs,
  output logic              ld_agex,
  output logic              agex_busy,
  output logic              v_agex_ld_reg,
  output logic              v_agex_ld_cc,
  output logic              v_agex_br_stall
);
  logic [DATA_W-1:0] addr1, addr2, addr2_sh, address, alu_b, alu_out, bar_out, step_out, shift_res, result;
  logic [DATA_W-1:0] acc, acc_nxt;
  logic [3:0]        cnt, cnt_nxt;
  state_e            state, state_nxt;
  aluk_e             aluk;
  logic              start, ld_mem;

  agex_shift_unit #(.DATA_W(DATA_W)) u_shift (
    .bar_in  (agex_sr1),
    .amt     (agex_ir[3:0]),
    .step_in (acc),
    .mode    (agex_ir[5:4]),
    .bar_out (bar_out),
    .step_out(step_out)
  );

  // address adder, ALU and result selection
  always_comb begin
    addr1     = agex_cs[CS_ADDR1MUX] ? agex_sr1 : agex_npc;
    addr2     = agex_cs[CS_ADDR2MUX+1] ? (agex_cs[CS_ADDR2MUX] ? DATA_W'($signed(agex_ir[10:0])) : DATA_W'($signed(agex_ir[8:0])))
                                       : (agex_cs[CS_ADDR2MUX] ? DATA_W'($signed(agex_ir[5:0])) : '0);
    addr2_sh  = agex_cs[CS_LSHF1] ? addr2 << 1 : addr2;
    address   = agex_cs[CS_ADDRESSMUX] ? addr1 + addr2_sh : DATA_W'({agex_ir[7:0], 1'b0});
    alu_b     = agex_cs[CS_SR2MUX] ? DATA_W'($signed(agex_ir[4:0])) : agex_sr2;
    aluk      = aluk_e'(agex_cs[CS_ALUK +: 2]);
    alu_out   = aluk == ALUK_ADD ? agex_sr1 + alu_b :
                aluk == ALUK_AND ? agex_sr1 & alu_b :
                aluk == ALUK_XOR ? agex_sr1 ^ alu_b : agex_sr1;
    shift_res = state == SHIFT ? acc : bar_out;
    result    = agex_cs[CS_RESULTMUX] ? alu_out : shift_res;
  end

  assign v_agex_ld_reg   = agex_v & agex_cs[CS_LD_REG] & ~flush;
  assign v_agex_ld_cc    = agex_v & agex_cs[CS_LD_CC] & ~flush;
  assign v_agex_br_stall = agex_v & agex_cs[CS_BR_STALL] & ~flush;

  // shifter FSM next state; start can only fire in the iterative build, so state stays IDLE otherwise
  always_comb begin
    start     = (SHIFT_ITER != 0) && state == IDLE && agex_v && !agex_cs[CS_RESULTMUX] && agex_ir[3:0] != 4'd0 && !flush && !mem_stall;
    agex_busy = start || (state == SHIFT && cnt != 4'd0);
    ld_agex   = ~mem_stall & ~agex_busy;
    ld_mem    = ld_agex;
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    if (flush) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else if (start) begin
      state_nxt = SHIFT;
      acc_nxt   = agex_sr1;
      cnt_nxt   = agex_ir[3:0];
    end else if (state == SHIFT && !mem_stall) begin
      state_nxt = cnt != 4'd0 ? SHIFT : IDLE;
      acc_nxt   = cnt != 4'd0 ? step_out : acc;
      cnt_nxt   = cnt != 4'd0 ? cnt - 4'd1 : cnt;
    end
  end

  // shifter FSM registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // MEM latch: flush or normal load, bubble while the shifter is busy, hold on stall
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_v          <= 1'b0;
      mem_npc        <= '0;
      mem_ir         <= '0;
      mem_alu_result <= '0;
      mem_address    <= '0;
      mem_cc         <= '0;
      mem_drid       <= '0;
      mem_cs         <= '0;
    end else if (flush || ld_mem) begin
      mem_v          <= agex_v & ~flush;
      mem_npc        <= agex_npc;
      mem_ir         <= agex_ir;
      mem_alu_result <= result;
      mem_address    <= address;
      mem_cc         <= agex_cc;
      mem_drid       <= agex_drid;
      mem_cs         <= agex_cs[CS_MEM_HI:CS_MEM_LO];
    end else if (!mem_stall) begin
      mem_v <= 1'b0;
    end
  end
endmodule

// File: tb/tb_agex_stage_pipe.sv
// tb_agex_stage_pipe: scoreboard bench for the AGEX stage, iterative and barrel shifter builds
module tb_agex_stage_pipe;
  logic clk = 1'b0;
  logic rst, agex_v, mem_stall, flush;
  logic [15:0] agex_npc, agex_ir, agex_sr1, agex_sr2;
  logic [2:0]  agex_cc, agex_drid;
  logic [19:0] agex_cs;
  logic mem_v, ld_agex, agex_busy, v_agex_ld_reg, v_agex_ld_cc, v_agex_br_stall;
  logic [15:0] mem_npc, mem_ir, mem_alu_result, mem_address;
  logic [2:0]  mem_cc, mem_drid;
  logic [10:0] mem_cs;
  logic b_mem_v, b_ld_agex, b_agex_busy, b_v_ld_reg, b_v_ld_cc, b_v_br_stall;
  logic [15:0] b_mem_npc, b_mem_ir, b_mem_alu_result, b_mem_address;
  logic [2:0]  b_mem_cc, b_mem_drid;
  logic [10:0] b_mem_cs;

  typedef struct packed {logic [15:0] alu; logic [15:0] addr; logic [10:0] cs;} exp_t;
  exp_t q[$];
  int n_chk = 0, n_fail = 0;
  logic hold_l = 1'b1;

  always #5 clk = ~clk;

  agex_stage_pipe #(.DATA_W(16), .SHIFT_ITER(1)) u_dut (
    .clk(clk), .rst(rst), .agex_v(agex_v), .agex_npc(agex_npc), .agex_ir(agex_ir),
    .agex_sr1(agex_sr1), .agex_sr2(agex_sr2), .agex_cc(agex_cc), .agex_drid(agex_drid),
    .agex_cs(agex_cs), .mem_stall(mem_stall), .flush(flush), .mem_v(mem_v), .mem_npc(mem_npc),
    .mem_ir(mem_ir), .mem_alu_result(mem_alu_result), .mem_address(mem_address), .mem_cc(mem_cc),
    .mem_drid(mem_drid), .mem_cs(mem_cs), .ld_agex(ld_agex), .agex_busy(agex_busy),
    .v_agex_ld_reg(v_agex_ld_reg), .v_agex_ld_cc(v_agex_ld_cc), .v_agex_br_stall(v_agex_br_stall)
  );

  agex_stage_pipe #(.DATA_W(16), .SHIFT_ITER(0)) u_bar (
    .clk(clk), .rst(rst), .agex_v(agex_v), .agex_npc(agex_npc), .agex_ir(agex_ir),
    .agex_sr1(agex_sr1), .agex_sr2(agex_sr2), .agex_cc(agex_cc), .agex_drid(agex_drid),
    .agex_cs(agex_cs), .mem_stall(mem_stall), .flush(flush), .mem_v(b_mem_v), .mem_npc(b_mem_npc),
    .mem_ir(b_mem_ir), .mem_alu_result(b_mem_alu_result), .mem_address(b_mem_address), .mem_cc(b_mem_cc),
    .mem_drid(b_mem_drid), .mem_cs(b_mem_cs), .ld_agex(b_ld_agex), .agex_busy(b_agex_busy),
    .v_agex_ld_reg(b_v_ld_reg), .v_agex_ld_cc(b_v_ld_cc), .v_agex_br_stall(b_v_br_stall)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [19:0] mk(input logic a1, input logic [1:0] a2, input logic ls, input logic am,
                                     input logic s2, input logic [1:0] ak, input logic rm, input logic [10:0] mb);
    return {mb, rm, ak, s2, am, ls, a2, a1};
  endfunction

  always @(posedge clk) hold_l <= rst | flush | mem_stall;

  always @(negedge clk) begin
    if (!hold_l && mem_v) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_spurious: got mem_v=1 alu=%h expected no output", mem_alu_result);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("sb_alu", {16'h0, mem_alu_result}, {16'h0, e.alu});
        check("sb_addr", {16'h0, mem_address}, {16'h0, e.addr});
        check("sb_cs", {21'h0, mem_cs}, {21'h0, e.cs});
      end
    end
  end

  task automatic drive(input logic [15:0] npc, input logic [15:0] ir, input logic [15:0] s1,
                       input logic [15:0] s2, input logic [19:0] cs);
    agex_v = 1'b1; agex_npc = npc; agex_ir = ir; agex_sr1 = s1; agex_sr2 = s2; agex_cs = cs;
    agex_cc = 3'b010; agex_drid = 3'd5;
  endtask

  task automatic issue(input logic [15:0] npc, input logic [15:0] ir, input logic [15:0] s1,
                       input logic [15:0] s2, input logic [19:0] cs, input logic [15:0] e_alu,
                       input logic [15:0] e_addr, input int e_cyc);
    int n;
    logic took;
    n = 0;
    took = 1'b0;
    drive(npc, ir, s1, s2, cs);
    q.push_back(exp_t'{e_alu, e_addr, cs[19:9]});
    while (!took && n < 40) begin
      @(negedge clk);
      took = ld_agex;
      @(posedge clk);
      #1;
      n++;
    end
    check("latency", n, e_cyc);
    check("bar_alu", {16'h0, b_mem_alu_result}, {16'h0, e_alu});
    agex_v = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_n, bub_n;
    rst = 1'b1; agex_v = 1'b1; mem_stall = 1'b0; flush = 1'b0;
    agex_npc = 16'h1234; agex_ir = 16'hFFFF; agex_sr1 = 16'h5555; agex_sr2 = 16'hAAAA;
    agex_cc = 3'b101; agex_drid = 3'd3; agex_cs = '1;
    repeat (2) @(posedge clk);
    #1;
    agex_v = 1'b0;
    rst = 1'b0;
    #1;
    check("rst_mem_v", mem_v, 0);
    check("rst_npc", mem_npc, 0);
    check("rst_alu", mem_alu_result, 0);
    check("rst_cs", mem_cs, 0);
    check("rst_busy", agex_busy, 0);
    check("rst_ld_agex", ld_agex, 1);
    check("v_ld_reg_idle", v_agex_ld_reg, 0);
    mem_stall = 1'b1;
    #1;
    check("ld_agex_stall", ld_agex, 0);
    mem_stall = 1'b0;
    @(posedge clk);
    #1;
    issue(16'h3002, 16'h003C, 16'h1000, 16'h0000, mk(1, 2'b01, 0, 1, 0, 2'b00, 1, 11'h123), 16'h1000, 16'h0FFC, 1);
    issue(16'h3002, 16'h003C, 16'h1000, 16'h0000, mk(1, 2'b01, 1, 1, 0, 2'b00, 1, 11'h456), 16'h1000, 16'h0FF8, 1);
    issue(16'h3002, 16'h0020, 16'h1000, 16'h0000, mk(1, 2'b01, 0, 0, 0, 2'b00, 1, 11'h789), 16'h1000, 16'h0040, 1);
    issue(16'h3002, 16'h01FE, 16'h1000, 16'h0000, mk(0, 2'b10, 0, 1, 0, 2'b00, 1, 11'h001), 16'h1000, 16'h3000, 1);
    issue(16'h3002, 16'h0400, 16'h1000, 16'h0000, mk(0, 2'b11, 0, 1, 0, 2'b00, 1, 11'h7FE), 16'h1000, 16'h2C02, 1);
    issue(16'h3000, 16'h0000, 16'h0003, 16'h0004, mk(0, 2'b00, 0, 1, 0, 2'b00, 1, 11'h010), 16'h0007, 16'h3000, 1);
    issue(16'h3000, 16'h001F, 16'h00F0, 16'h0000, mk(0, 2'b00, 0, 1, 1, 2'b01, 1, 11'h020), 16'h00F0, 16'h3000, 1);
    issue(16'h3000, 16'h0000, 16'h0F0F, 16'h00FF, mk(0, 2'b00, 0, 1, 0, 2'b10, 1, 11'h040), 16'h0FF0, 16'h3000, 1);
    issue(16'h3000, 16'h0000, 16'hBEEF, 16'h1234, mk(0, 2'b00, 0, 1, 0, 2'b11, 1, 11'h080), 16'hBEEF, 16'h3000, 1);
    issue(16'h3000, 16'h0000, 16'hFFFF, 16'h0002, mk(0, 2'b00, 0, 1, 0, 2'b00, 1, 11'h100), 16'h0001, 16'h3000, 1);
    issue(16'h3000, 16'h0030, 16'h8001, 16'h0000, mk(0, 2'b00, 0, 1, 0, 2'b00, 0, 11'h200), 16'h8001, 16'h3000, 1);
    issue(16'h3000, 16'h0004, 16'h0123, 16'h0000, mk(0, 2'b00, 0, 1, 0, 2'b00, 0, 11'h400), 16'h1230, 16'h3000, 6);
    issue(16'h3000, 16'h0011, 16'h8000, 16'h0000, mk(0, 2'b00, 0, 1, 0, 2'b00, 0, 11'h555), 16'h4000, 16'h3000, 3);
    drive(16'h3000, 16'h0033, 16'h8000, 16'h0000, mk(0, 2'b00, 0, 1, 0, 2'b00, 0, 11'h7FF));
    q.push_back(exp_t'{16'hF000, 16'h3000, 11'h7FF});
    busy_n = 0;
    bub_n = 0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      busy_n += int'(agex_busy);
      @(posedge clk);
      #1;
      if (k == 1) begin
        check("bar_sra", {16'h0, b_mem_alu_result}, 32'h0000F000);
        check("bar_sra_v", b_mem_v, 1);
      end
      if (k < 5 && !mem_v) bub_n++;
    end
    check("busy_cycles", busy_n, 4);
    check("bubbles", bub_n, 4);
    drive(16'h3000, 16'h0002, 16'h0003, 16'h0000, mk(0, 2'b00, 0, 1, 0, 2'b00, 0, 11'h0F0));
    repeat (3) @(posedge clk);
    #1;
    check("done_busy", agex_busy, 0);
    mem_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check("stall_mem_v", mem_v, 0);
      check("stall_alu", {16'h0, mem_alu_result}, 32'h0000F000);
      check("stall_ld_agex", ld_agex, 0);
    end
    q.push_back(exp_t'{16'h000C, 16'h3000, 11'h0F0});
    mem_stall = 1'b0;
    @(posedge clk);
    #1;
    agex_v = 1'b0;
    drive(16'h3000, 16'h0014, 16'hF000, 16'h0000, mk(0, 2'b00, 0, 1, 0, 2'b00, 0, 11'h608));
    #1;
    check("v_ld_reg_on", v_agex_ld_reg, 1);
    repeat (3) @(posedge clk);
    #1;
    check("mid_shift_busy", agex_busy, 1);
    flush = 1'b1;
    mem_stall = 1'b1;
    #1;
    check("flush_v_ld_reg", v_agex_ld_reg, 0);
    check("flush_v_ld_cc", v_agex_ld_cc, 0);
    check("flush_v_br_stall", v_agex_br_stall, 0);
    @(posedge clk);
    #1;
    check("flush_mem_v", mem_v, 0);
    flush = 1'b0;
    mem_stall = 1'b0;
    agex_v = 1'b0;
    #1;
    check("flush_busy", agex_busy, 0);
    check("flush_ld_agex", ld_agex, 1);
    drive(16'h3000, 16'h0005, 16'h1111, 16'h0000, mk(0, 2'b00, 0, 1, 0, 2'b00, 0, 11'h608));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    flush = 1'b1;
    mem_stall = 1'b1;
    @(posedge clk);
    #1;
    check("rst2_mem_v", mem_v, 0);
    check("rst2_npc", {16'h0, mem_npc}, 0);
    check("rst2_ir", {16'h0, mem_ir}, 0);
    check("rst2_alu", {16'h0, mem_alu_result}, 0);
    check("rst2_addr", {16'h0, mem_address}, 0);
    check("rst2_cc", mem_cc, 0);
    check("rst2_drid", mem_drid, 0);
    check("rst2_cs", mem_cs, 0);
    rst = 1'b0;
    flush = 1'b0;
    mem_stall = 1'b0;
    agex_v = 1'b0;
    #1;
    check("rst2_busy", agex_busy, 0);
    check("rst2_v_ld_reg", v_agex_ld_reg, 0);
    check("rst2_v_ld_cc", v_agex_ld_cc, 0);
    check("rst2_v_br_stall", v_agex_br_stall, 0);
    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
